// File: rtl/fft_stage_scheduler_if.sv
// Handshake and memory-control bundle between the FFT stage scheduler and its datapath
// (sample RAM, twiddle ROM and butterfly).
interface fft_stage_scheduler_if #(
   parameter int N_LOG2  = 10,
   parameter int STAGE_W = 4
);
   logic                i_start;
   logic                o_busy;
   logic                o_done;
   logic [STAGE_W-1:0]  o_stage;
   logic                o_rd_en;
   logic [N_LOG2-1:0]   o_rd_addr_a;
   logic [N_LOG2-1:0]   o_rd_addr_b;
   logic [N_LOG2-2:0]   o_tw_addr;
   logic                o_bf_start;
   logic                i_bf_valid;
   logic                o_wr_en;
   logic [N_LOG2-1:0]   o_wr_addr_a;
   logic [N_LOG2-1:0]   o_wr_addr_b;
   logic                o_error;

   modport master (
      input  i_start,
      input  i_bf_valid,
      output o_busy,
      output o_done,
      output o_stage,
      output o_rd_en,
      output o_rd_addr_a,
      output o_rd_addr_b,
      output o_tw_addr,
      output o_bf_start,
      output o_wr_en,
      output o_wr_addr_a,
      output o_wr_addr_b,
      output o_error
   );

   modport slave (
      output i_start,
      output i_bf_valid,
      input  o_busy,
      input  o_done,
      input  o_stage,
      input  o_rd_en,
      input  o_rd_addr_a,
      input  o_rd_addr_b,
      input  o_tw_addr,
      input  o_bf_start,
      input  o_wr_en,
      input  o_wr_addr_a,
      input  o_wr_addr_b,
      input  o_error
   );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Radix-2 DIT in-place FFT stage scheduler: issues N/2 butterfly reads per stage, tracks them
// through the butterfly latency and issues the matching write-back, stage by stage.
module fft_stage_scheduler #(
   parameter int N_LOG2     = 10,
   parameter int BF_LATENCY = 3,
   parameter int STAGE_W    = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fft_stage_scheduler_if.master bus
);
   localparam int                 K_W        = N_LOG2 - 1;
   localparam logic [K_W-1:0]     K_LAST     = '1;
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state_q,     state_d;
   logic [K_W-1:0]     k_q,         k_d;
   logic [STAGE_W-1:0] stage_q,     stage_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               error_q,     error_d;
   logic               rd_en_q,     rd_en_d;
   logic [N_LOG2-1:0]  rd_addr_a_q, rd_addr_a_d;
   logic [N_LOG2-1:0]  rd_addr_b_q, rd_addr_b_d;
   logic [K_W-1:0]     tw_addr_q,   tw_addr_d;

   // Index 0 is the butterfly start cycle, index BF_LATENCY is the write-back cycle.
   logic               dl_vld_q [0:BF_LATENCY];
   logic               dl_vld_d [0:BF_LATENCY];
   logic [N_LOG2-1:0]  dl_a_q   [0:BF_LATENCY];
   logic [N_LOG2-1:0]  dl_a_d   [0:BF_LATENCY];
   logic [N_LOG2-1:0]  dl_b_q   [0:BF_LATENCY];
   logic [N_LOG2-1:0]  dl_b_d   [0:BF_LATENCY];

   logic [N_LOG2-1:0]  k_ext;
   logic [N_LOG2-1:0]  half;
   logic [N_LOG2-1:0]  pos;
   logic [N_LOG2-1:0]  grp_base;
   logic [N_LOG2-1:0]  addr_a;
   logic [N_LOG2-1:0]  addr_b;
   logic [STAGE_W-1:0] tw_shift;
   logic               wr_exp;
   logic               pending;

   always_comb begin
      k_ext    = {1'b0, k_q};
      half     = {{(N_LOG2-1){1'b0}}, 1'b1} << stage_q;
      pos      = k_ext & (half - 1'b1);
      grp_base = (k_ext >> stage_q) << (stage_q + 1'b1);
      addr_a   = grp_base | pos;
      addr_b   = addr_a | half;
      tw_shift = STAGE_LAST - stage_q;
   end

   // The final write of a stage is allowed to coincide with the decision to restart ISSUE,
   // because the next read only appears one cycle after that decision.
   always_comb begin
      wr_exp  = dl_vld_q[BF_LATENCY];
      pending = rd_en_q;
      for (int i = 0; i < BF_LATENCY - 1; i++) begin
         pending = pending | dl_vld_q[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      stage_d     = stage_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      rd_addr_a_d = '0;
      rd_addr_b_d = '0;
      tw_addr_d   = '0;
      error_d     = error_q | (bus.i_bf_valid != wr_exp);

      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               state_d = ISSUE;
               k_d     = '0;
               stage_d = '0;
               error_d = 1'b0;
            end
         end
         ISSUE: begin
            busy_d      = 1'b1;
            rd_en_d     = 1'b1;
            rd_addr_a_d = addr_a;
            rd_addr_b_d = addr_b;
            tw_addr_d   = K_W'(pos << tw_shift);
            k_d         = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d = DRAIN;
               k_d     = '0;
            end
         end
         DRAIN: begin
            busy_d = 1'b1;
            if (!pending) begin
               if (stage_q == STAGE_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + 1'b1;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            stage_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dl_vld_d[0] = rd_en_q;
      dl_a_d[0]   = rd_addr_a_q;
      dl_b_d[0]   = rd_addr_b_q;
      for (int i = 1; i <= BF_LATENCY; i++) begin
         dl_vld_d[i] = dl_vld_q[i-1];
         dl_a_d[i]   = dl_a_q[i-1];
         dl_b_d[i]   = dl_b_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         stage_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         tw_addr_q   <= '0;
         for (int i = 0; i <= BF_LATENCY; i++) begin
            dl_vld_q[i] <= 1'b0;
            dl_a_q[i]   <= '0;
            dl_b_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         stage_q     <= stage_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         tw_addr_q   <= tw_addr_d;
         for (int i = 0; i <= BF_LATENCY; i++) begin
            dl_vld_q[i] <= dl_vld_d[i];
            dl_a_q[i]   <= dl_a_d[i];
            dl_b_q[i]   <= dl_b_d[i];
         end
      end
   end

   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_stage     = stage_q;
   assign bus.o_rd_en     = rd_en_q;
   assign bus.o_rd_addr_a = rd_addr_a_q;
   assign bus.o_rd_addr_b = rd_addr_b_q;
   assign bus.o_tw_addr   = tw_addr_q;
   assign bus.o_bf_start  = dl_vld_q[0];
   assign bus.o_wr_en     = dl_vld_q[BF_LATENCY];
   assign bus.o_wr_addr_a = dl_a_q[BF_LATENCY];
   assign bus.o_wr_addr_b = dl_b_q[BF_LATENCY];
   assign bus.o_error     = error_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler at N_LOG2=3, BF_LATENCY=3 with a shift-register
// butterfly model whose latency can be changed per run.
module tb_fft_stage_scheduler;
   localparam int N_LOG2     = 3;
   localparam int BF_LATENCY = 3;
   localparam int STAGE_W    = 4;

   logic clk = 1'b0;
   logic reset_n;

   fft_stage_scheduler_if #(.N_LOG2(N_LOG2), .STAGE_W(STAGE_W)) bus ();

   fft_stage_scheduler #(
      .N_LOG2    (N_LOG2),
      .BF_LATENCY(BF_LATENCY),
      .STAGE_W   (STAGE_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Butterfly model: o_bf_start delayed so i_bf_valid is high during the cycle
   // bf_lat cycles after the start strobe.
   int          bf_lat = 3;
   logic [15:0] sr     = '0;
   always @(negedge clk) begin
      if (!reset_n) sr = '0;
      else          sr = {sr[14:0], bus.o_bf_start};
      bus.i_bf_valid = sr[bf_lat];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [31:0] m_rd, m_bf, m_wr, m_busy, m_done, m_err;
   int rd_n, wr_n, zero_viol;
   int rd_a [16], rd_b [16], rd_tw [16], rd_st [16];
   int wr_a [16], wr_b [16];

   int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int exp_st [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

   task automatic sample(input int c);
      m_rd[c]   = bus.o_rd_en;
      m_bf[c]   = bus.o_bf_start;
      m_wr[c]   = bus.o_wr_en;
      m_busy[c] = bus.o_busy;
      m_done[c] = bus.o_done;
      m_err[c]  = bus.o_error;
      if (bus.o_rd_en) begin
         if (rd_n < 16) begin
            rd_a[rd_n]  = int'(bus.o_rd_addr_a);
            rd_b[rd_n]  = int'(bus.o_rd_addr_b);
            rd_tw[rd_n] = int'(bus.o_tw_addr);
            rd_st[rd_n] = int'(bus.o_stage);
         end
         rd_n++;
      end else if (bus.o_rd_addr_a != 0 || bus.o_rd_addr_b != 0 || bus.o_tw_addr != 0) begin
         zero_viol++;
      end
      if (bus.o_wr_en) begin
         if (wr_n < 16) begin
            wr_a[wr_n] = int'(bus.o_wr_addr_a);
            wr_b[wr_n] = int'(bus.o_wr_addr_b);
         end
         wr_n++;
      end else if (bus.o_wr_addr_a != 0 || bus.o_wr_addr_b != 0) begin
         zero_viol++;
      end
   endtask

   // Cycle 0 is the sample point just after the edge that accepted i_start.
   task automatic record_run(input int n);
      m_rd = '0; m_bf = '0; m_wr = '0; m_busy = '0; m_done = '0; m_err = '0;
      rd_n = 0; wr_n = 0; zero_viol = 0;
      for (int c = 0; c < n; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         sample(c);
      end
   endtask

   task automatic start_pulse();
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic check_nominal(input string t);
      chk({t, "_rd_cycles"},   m_rd,   32'h001E_1E1E);
      chk({t, "_bf_cycles"},   m_bf,   32'h003C_3C3C);
      chk({t, "_wr_cycles"},   m_wr,   32'h01E1_E1E0);
      chk({t, "_busy_cycles"}, m_busy, 32'h01FF_FFFE);
      chk({t, "_done_cycles"}, m_done, 32'h0200_0000);
      chk({t, "_error"},       m_err,  32'h0);
      chk({t, "_rd_count"},    rd_n,   12);
      chk({t, "_wr_count"},    wr_n,   12);
      chk({t, "_idle_addr"},   zero_viol, 0);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("%s_rd%0d_a", t, i),  rd_a[i],  exp_a[i]);
         chk($sformatf("%s_rd%0d_b", t, i),  rd_b[i],  exp_b[i]);
         chk($sformatf("%s_rd%0d_tw", t, i), rd_tw[i], exp_tw[i]);
         chk($sformatf("%s_rd%0d_st", t, i), rd_st[i], exp_st[i]);
         chk($sformatf("%s_wr%0d_a", t, i),  wr_a[i],  exp_a[i]);
         chk($sformatf("%s_wr%0d_b", t, i),  wr_b[i],  exp_b[i]);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {bus.o_busy, bus.o_done, bus.o_stage, bus.o_rd_en, bus.o_rd_addr_a,
              bus.o_rd_addr_b, bus.o_tw_addr, bus.o_bf_start, bus.o_wr_en,
              bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_error};
   endfunction

   initial begin
      int n_done;
      logic [31:0] act;

      reset_n     = 1'b0;
      bus.i_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(all_outputs()), 32'h0);
      chk("reset_busy",    bus.o_busy,  0);
      chk("reset_error",   bus.o_error, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Nominal transform.
      start_pulse();
      record_run(32);
      check_nominal("nom");

      // i_start held high: one transform, then a fresh one from IDLE.
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      record_run(32);
      bus.i_start = 1'b0;
      chk("held_rd_cycles",   m_rd,   32'h781E_1E1E);
      chk("held_bf_cycles",   m_bf,   32'hF03C_3C3C);
      chk("held_wr_cycles",   m_wr,   32'h81E1_E1E0);
      chk("held_busy_cycles", m_busy, 32'hF9FF_FFFE);
      chk("held_done_cycles", m_done, 32'h0200_0000);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) n_done++;
      end
      chk("held_second_done", n_done, 1);
      chk("held_idle_busy",   bus.o_busy, 0);

      // Butterfly one cycle late: sticky error, writes still on the expected strobe.
      bf_lat = 4;
      start_pulse();
      record_run(32);
      chk("lat4_wr_cycles",  m_wr,  32'h01E1_E1E0);
      chk("lat4_err_cycles", m_err, 32'hFFFF_FFC0);
      repeat (8) @(posedge clk);
      #1;
      chk("lat4_err_sticky", bus.o_error, 1);
      bf_lat = 3;
      start_pulse();
      record_run(32);
      check_nominal("clr");

      // Reset during stage 1 DRAIN.
      start_pulse();
      repeat (13) @(posedge clk);
      #1;
      chk("mid_wr_en", bus.o_wr_en, 1);
      chk("mid_stage", bus.o_stage, 1);
      chk("mid_busy",  bus.o_busy,  1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_outputs", 32'(all_outputs()), 32'h0);
      chk("rst_outputs_hi", 32'(all_outputs() >> 32), 32'h0);
      reset_n = 1'b1;
      act = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         act[i] = bus.o_rd_en | bus.o_wr_en | bus.o_bf_start | bus.o_busy | bus.o_done | bus.o_error;
      end
      chk("rst_quiet", act, 32'h0);
      start_pulse();
      record_run(32);
      check_nominal("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fft_stage_scheduler.md
FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 SHALL have parameter N_LOG2, default 10, meaning log2 of FFT length N (N = 2^N_LOG2, legal range 2..12).
REQ-002 SHALL have parameter BF_LATENCY, default 3, meaning cycles from butterfly i_start to its o_valid.
REQ-003 SHALL have parameter STAGE_W, default 4, meaning width of the stage index output.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  meaning reset, synchronous and active-low.
REQ-006 SHALL have port i_start  input  1  meaning request one full N-point transform.
REQ-007 SHALL have port o_busy  output  1  meaning transform in progress.
REQ-008 SHALL have port o_done  output  1  meaning one-cycle pulse when the transform completes.
REQ-009 SHALL have port o_stage  output  STAGE_W  meaning current stage index 0..N_LOG2-1.
REQ-010 SHALL have ports o_rd_en (1), o_rd_addr_a and o_rd_addr_b (N_LOG2 each), all outputs, meaning sample RAM read request and the two operand addresses.
REQ-011 SHALL have port o_tw_addr  output  N_LOG2-1  meaning twiddle ROM index, issued with o_rd_en.
REQ-012 SHALL have port o_bf_start  output  1  meaning start strobe to the butterfly.
REQ-013 SHALL have port i_bf_valid  input  1  meaning butterfly output valid.
REQ-014 SHALL have ports o_wr_en (1), o_wr_addr_a and o_wr_addr_b (N_LOG2 each), all outputs, meaning in-place write-back of the butterfly results.
REQ-015 SHALL have port o_error  output  1  meaning sticky flag for butterfly valid misalignment.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-017 SHALL move from IDLE to ISSUE when i_start=1; stage=0 and k=0; i_start SHALL be ignored in every other state.
REQ-018 SHALL, in ISSUE, assert o_rd_en for exactly N/2 consecutive cycles, one per butterfly index k=0..N/2-1, with no gaps.
REQ-019 SHALL generate addresses for stage s as: half=2^s, pos=k mod half, grp=k>>s, addr_a=grp*2*half+pos, addr_b=addr_a+half, tw=pos<<(N_LOG2-1-s) (radix-2 DIT, in place; input assumed bit-reversed).
REQ-020 SHALL assert o_bf_start exactly one cycle after each o_rd_en cycle (one-cycle RAM read latency).
REQ-021 SHALL carry each addr_a/addr_b pair through a delay line of depth 1+BF_LATENCY, asserting o_wr_en with those addresses exactly BF_LATENCY cycles after the matching o_bf_start.
REQ-022 SHALL set o_error and keep it set until reset or the next accepted i_start whenever i_bf_valid differs from the internally expected write strobe; o_wr_en SHALL follow the expected strobe, not i_bf_valid.
REQ-023 SHALL enter DRAIN after the last ISSUE cycle and stay there until no butterfly remains in flight, so stage s+1 reads never precede stage s writes.
REQ-024 SHALL, in the cycle after the final write of a stage, enter ISSUE with stage+1 and k=0, or enter DONE if stage=N_LOG2-1; stage period = N/2+1+BF_LATENCY cycles.
REQ-025 SHALL pulse o_done for one cycle in DONE, then return to IDLE; o_busy=1 in ISSUE and DRAIN only.
REQ-026 SHALL drive o_rd_addr_*, o_tw_addr and o_wr_addr_* to 0 whenever the associated enable is 0.

Reset
REQ-027 SHALL, when reset_n=0 at a clock edge, enter IDLE, clear the delay line, k and stage, and drive every output to 0, including mid-transform; no write SHALL follow reset.

Verification
REQ-028 SHALL test N_LOG2=3, BF_LATENCY=3: pulse i_start with a model butterfly -> o_rd_en in cycles 1-4, 9-12, 17-20 after the start edge, o_done at cycle 25, o_error=0.
REQ-029 SHALL test the same run for addresses: stage0 k=1 -> a=2, b=3, tw=0; stage1 k=1 -> a=1, b=3, tw=2; stage2 k=3 -> a=3, b=7, tw=3.
REQ-030 SHALL test write alignment: every o_wr_en occurs 4 cycles after its o_rd_en with identical addresses; no stage-1 read occurs before the last stage-0 write.
REQ-031 SHALL test i_start held high throughout the run -> exactly one transform, one o_done, then a restart from IDLE.
REQ-032 SHALL test a butterfly model with latency 4 -> o_error=1 at the first expected write and stays 1; the next i_start clears it.
REQ-033 SHALL test reset_n=0 during stage 1 DRAIN -> next cycle all outputs 0; a fresh i_start then produces the full REQ-028 sequence.
